// File: rtl/dispatch_pkg.sv
// Shared types and default widths for the dual-stream dispatch controller.
// Pure declarations: no latency or flow control of its own.
package dispatch_pkg;

    localparam int AW_DEF = 8;
    localparam int CW_DEF = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/stream_ptr.sv
// One stream's data pointer, saturating issue counter and wrap-to-base detector.
// Updates one cycle after load_i/inc_i; has no flow control of its own.
module stream_ptr
    import dispatch_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int CW = CW_DEF
) (
    input  logic          clk,
    input  logic          rst_i,
    input  logic          load_i,
    input  logic [AW-1:0] base_i,
    input  logic          inc_i,
    output logic [AW-1:0] dp_o,
    output logic [CW-1:0] cnt_o,
    output logic          dead_o
);

    logic [AW-1:0] dp_q, dp_d;
    logic [AW-1:0] base_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          dead_q;

    always_comb begin
        dp_d  = dp_q + AW'(1);
        cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + CW'(1);
    end

    // The base is captured at load so the wrap check compares against the run's own start address.
    always_ff @(posedge clk) begin
        if (rst_i) begin
            dp_q   <= '0;
            base_q <= '0;
            cnt_q  <= '0;
            dead_q <= 1'b0;
        end else if (load_i) begin
            dp_q   <= base_i;
            base_q <= base_i;
            cnt_q  <= '0;
            dead_q <= 1'b0;
        end else if (inc_i) begin
            dp_q  <= dp_d;
            cnt_q <= cnt_d;
            if (dp_d == base_q) begin
                dead_q <= 1'b1;
            end
        end
    end

    assign dp_o   = dp_q;
    assign cnt_o  = cnt_q;
    assign dead_o = dead_q;

endmodule

// File: rtl/dispatch_ctrl.sv
// Dispatches words from two zero-terminated streams onto two FUs, swapping operand routing when one FU is busy.
// Issue valids are combinational from fuN_ready; a stream advances on the edge it is served, stalls while no FU is ready.
module dispatch_ctrl
    import dispatch_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int CW = CW_DEF
) (
    input  logic          clk,
    input  logic          preset,
    input  logic          start,
    input  logic [AW-1:0] base0,
    input  logic [AW-1:0] base1,
    input  logic          zer0,
    input  logic          zer1,
    input  logic          fu0_ready,
    input  logic          fu1_ready,
    output logic [AW-1:0] dp0,
    output logic [AW-1:0] dp1,
    output logic          selpath,
    output logic          fu0_valid,
    output logic          fu1_valid,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [CW-1:0] cnt0,
    output logic [CW-1:0] cnt1
);

    state_e state_q;
    logic   rr_q, rr_d;
    logic   selpath_q, selpath_d;
    logic   busy_q, done_q;
    logic   load;
    logic   dead0, dead1;
    logic   live0, live1;
    logic   serve0, serve1;
    logic   fu0_vld, fu1_vld;

    assign load = (state_q == IDLE) && start;

    stream_ptr #(.AW(AW), .CW(CW)) u_sp0 (
        .clk    (clk),
        .rst_i  (preset),
        .load_i (load),
        .base_i (base0),
        .inc_i  (serve0),
        .dp_o   (dp0),
        .cnt_o  (cnt0),
        .dead_o (dead0)
    );

    stream_ptr #(.AW(AW), .CW(CW)) u_sp1 (
        .clk    (clk),
        .rst_i  (preset),
        .load_i (load),
        .base_i (base1),
        .inc_i  (serve1),
        .dp_o   (dp1),
        .cnt_o  (cnt1),
        .dead_o (dead1)
    );

    assign live0 = ~zer0 & ~dead0;
    assign live1 = ~zer1 & ~dead1;

    // With a single FU free, a lone live stream goes to it; two live streams share it round-robin.
    always_comb begin
        serve0    = 1'b0;
        serve1    = 1'b0;
        fu0_vld   = 1'b0;
        fu1_vld   = 1'b0;
        selpath_d = selpath_q;
        rr_d      = rr_q;
        if (state_q == ISSUE && (live0 || live1)) begin
            unique case ({fu0_ready, fu1_ready})
                2'b11: begin
                    serve0    = live0;
                    serve1    = live1;
                    fu0_vld   = live0;
                    fu1_vld   = live1;
                    selpath_d = 1'b0;
                end
                2'b10: begin
                    fu0_vld = 1'b1;
                    if (live0 && live1) begin
                        serve0    = ~rr_q;
                        serve1    = rr_q;
                        selpath_d = rr_q;
                        rr_d      = ~rr_q;
                    end else begin
                        serve0    = live0;
                        serve1    = live1;
                        selpath_d = live1;
                    end
                end
                2'b01: begin
                    fu1_vld = 1'b1;
                    if (live0 && live1) begin
                        serve0    = ~rr_q;
                        serve1    = rr_q;
                        selpath_d = ~rr_q;
                        rr_d      = ~rr_q;
                    end else begin
                        serve0    = live0;
                        serve1    = live1;
                        selpath_d = live0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (preset) begin
            state_q   <= IDLE;
            rr_q      <= 1'b0;
            selpath_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            rr_q      <= rr_d;
            selpath_q <= selpath_d;
            done_q    <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= ISSUE;
                        busy_q  <= 1'b1;
                    end
                end
                ISSUE: begin
                    if (!live0 && !live1) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (fu0_ready && fu1_ready) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign selpath   = selpath_d;
    assign fu0_valid = fu0_vld;
    assign fu1_valid = fu1_vld;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = dead0 | dead1;

endmodule

// File: tb/tb_dispatch_ctrl.sv
// Directed bench for dispatch_ctrl: a stream-level reference model checked every cycle, plus literal checks per scenario.
module tb_dispatch_ctrl;

    localparam int AW = 8;
    localparam int CW = 16;
    localparam int P_IDLE  = 0;
    localparam int P_ISSUE = 1;
    localparam int P_DRAIN = 2;
    localparam int P_DONE  = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          preset, start, r0, r1;
    logic [AW-1:0] base0, base1, dp0, dp1;
    logic          zer0, zer1;
    logic          selpath, fu0_valid, fu1_valid, busy, done, err;
    logic [CW-1:0] cnt0, cnt1;
    logic [7:0]    mem0 [256];
    logic [7:0]    mem1 [256];

    assign zer0 = (mem0[dp0] == 8'h00);
    assign zer1 = (mem1[dp1] == 8'h00);

    dispatch_ctrl #(.AW(AW), .CW(CW)) u_dut (
        .clk(clk), .preset(preset), .start(start), .base0(base0), .base1(base1),
        .zer0(zer0), .zer1(zer1), .fu0_ready(r0), .fu1_ready(r1),
        .dp0(dp0), .dp1(dp1), .selpath(selpath), .fu0_valid(fu0_valid), .fu1_valid(fu1_valid),
        .busy(busy), .done(done), .err(err), .cnt0(cnt0), .cnt1(cnt1)
    );

    // Narrow-pointer instance for the wrap scenario; memory has no zero word.
    logic          start4;
    logic [3:0]    base4_0 = 4'h0;
    logic [3:0]    base4_1 = 4'h5;
    logic          zlo = 1'b0;
    logic          rhi = 1'b1;
    logic [3:0]    dp4_0, dp4_1;
    logic          sel4, v4_0, v4_1, busy4, done4, err4;
    logic [CW-1:0] cnt4_0, cnt4_1;

    dispatch_ctrl #(.AW(4), .CW(CW)) u_dut4 (
        .clk(clk), .preset(preset), .start(start4), .base0(base4_0), .base1(base4_1),
        .zer0(zlo), .zer1(zlo), .fu0_ready(rhi), .fu1_ready(rhi),
        .dp0(dp4_0), .dp1(dp4_1), .selpath(sel4), .fu0_valid(v4_0), .fu1_valid(v4_1),
        .busy(busy4), .done(done4), .err(err4), .cnt0(cnt4_0), .cnt1(cnt4_1)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit word_nz(input int s, input int a);
        return (s == 0) ? (mem0[a] != 8'h00) : (mem1[a] != 8'h00);
    endfunction

    // Reference model: streams are address walks over memory, FU assignment decided per cycle.
    int m_valid = 0;
    int m_phase = P_IDLE;
    int m_dp[2], m_base[2], m_cnt[2];
    bit m_dead[2];
    bit m_err, m_rr, m_sel;

    always @(negedge clk) begin : model
        bit lv[2];
        bit srv[2];
        bit ev0, ev1, esel;
        int s, fu;
        for (int i = 0; i < 2; i++) begin
            lv[i]  = (m_phase == P_ISSUE) && !m_dead[i] && word_nz(i, m_dp[i]);
            srv[i] = 1'b0;
        end
        ev0 = 1'b0; ev1 = 1'b0; esel = m_sel;
        if (m_phase == P_ISSUE && (lv[0] || lv[1])) begin
            if (r0 && r1) begin
                srv = lv; ev0 = lv[0]; ev1 = lv[1]; esel = 1'b0;
            end else if (r0 || r1) begin
                fu = r0 ? 0 : 1;
                s  = (lv[0] && lv[1]) ? int'(m_rr) : (lv[0] ? 0 : 1);
                srv[s] = 1'b1;
                if (fu == 0) ev0 = 1'b1; else ev1 = 1'b1;
                esel = (s != fu);
            end
        end
        if (m_valid != 0) begin
            check("cyc_dp0", dp0, m_dp[0]);
            check("cyc_dp1", dp1, m_dp[1]);
            check("cyc_cnt0", cnt0, m_cnt[0]);
            check("cyc_cnt1", cnt1, m_cnt[1]);
            check("cyc_err", err, m_err);
            check("cyc_busy", busy, (m_phase == P_ISSUE || m_phase == P_DRAIN));
            check("cyc_done", done, (m_phase == P_DONE));
            check("cyc_selpath", selpath, esel);
            check("cyc_fu0_valid", fu0_valid, ev0);
            check("cyc_fu1_valid", fu1_valid, ev1);
        end
        if (preset) begin
            m_valid = 1; m_phase = P_IDLE;
            m_dp = '{0, 0}; m_cnt = '{0, 0}; m_dead = '{0, 0};
            m_err = 0; m_rr = 0; m_sel = 0;
        end else if (m_valid != 0) begin
            m_sel = esel;
            for (int i = 0; i < 2; i++) begin
                if (srv[i]) begin
                    m_dp[i] = (m_dp[i] + 1) % 256;
                    if (m_cnt[i] < 65535) m_cnt[i]++;
                    if (m_dp[i] == m_base[i]) begin
                        m_dead[i] = 1; m_err = 1;
                    end
                end
            end
            if (m_phase == P_ISSUE && lv[0] && lv[1] && (r0 ^ r1)) m_rr = !m_rr;
            case (m_phase)
                P_IDLE: if (start) begin
                    m_phase = P_ISSUE;
                    m_base = '{int'(base0), int'(base1)};
                    m_dp = m_base; m_cnt = '{0, 0}; m_dead = '{0, 0}; m_err = 0;
                end
                P_ISSUE: if (!lv[0] && !lv[1]) m_phase = P_DRAIN;
                P_DRAIN: if (r0 && r1) m_phase = P_DONE;
                default: m_phase = P_IDLE;
            endcase
        end
    end

    int n_v0, n_v1, n_dual;
    bit sel_hist[$];

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) begin
            mem0[i] = 8'h00; mem1[i] = 8'h00;
        end
    endtask

    task automatic do_start(input logic [AW-1:0] b0, input logic [AW-1:0] b1);
        base0 = b0; base1 = b1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Runs from the first ISSUE cycle until done; n counts edges after the start-sampling edge.
    task automatic run_wait(input int budget, input int raise_at, input int pulse_at, output int n);
        n = 0; n_v0 = 0; n_v1 = 0; n_dual = 0;
        sel_hist.delete();
        while (1) begin
            if (fu0_valid) n_v0++;
            if (fu1_valid) n_v1++;
            if (fu0_valid && fu1_valid) n_dual++;
            if (fu0_valid || fu1_valid) sel_hist.push_back(selpath);
            if (done) break;
            if (n >= budget) begin
                checks++; errors++;
                $display("FAIL run_timeout cycles=%0d budget=%0d", n, budget);
                break;
            end
            @(posedge clk); #1;
            n++;
            if (raise_at >= 0 && n >= raise_at) r1 = 1'b1;
            start = (n == pulse_at);
        end
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int k;
        logic [3:0] seq;
        bit anysel;
        bit err_before, got_done;
        preset = 1'b1; start = 1'b0; start4 = 1'b0; r0 = 1'b1; r1 = 1'b1;
        base0 = '0; base1 = '0;
        clear_mem();
        repeat (2) @(posedge clk);
        #1;
        preset = 1'b0;
        check("rst_dp0", dp0, 0);
        check("rst_cnt1", cnt1, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_selpath", selpath, 0);
        @(posedge clk); #1;

        // Both streams three words long, both FUs always ready.
        clear_mem();
        for (int i = 0; i < 3; i++) begin
            mem0['h10 + i] = 8'hA0 + 8'(i); mem1['h20 + i] = 8'hB0 + 8'(i);
        end
        do_start(8'h10, 8'h20);
        run_wait(20, -1, -1, n);
        check("s1_done_latency", n, 5);
        check("s1_dual_issues", n_dual, 3);
        anysel = 1'b0;
        foreach (sel_hist[i]) anysel |= sel_hist[i];
        check("s1_selpath_any", anysel, 0);
        check("s1_cnt0", cnt0, 3);
        check("s1_cnt1", cnt1, 3);
        check("s1_dp0", dp0, 8'h13);
        check("s1_err", err, 0);
        @(posedge clk); #1;

        // Only FU0 ready, both streams live: round-robin through the swapped path.
        clear_mem();
        for (int i = 0; i < 2; i++) begin
            mem0['h30 + i] = 8'h11; mem1['h40 + i] = 8'h22;
        end
        r1 = 1'b0;
        do_start(8'h30, 8'h40);
        run_wait(30, 8, -1, n);
        check("s2_issue_count", sel_hist.size(), 4);
        seq = 4'b0000;
        for (int i = 0; i < 4 && i < sel_hist.size(); i++) seq[i] = sel_hist[i];
        check("s2_selpath_seq", seq, 4'b1010);
        check("s2_fu1_issues", n_v1, 0);
        check("s2_dp0", dp0, 8'h32);
        check("s2_dp1", dp1, 8'h42);
        check("s2_cnt0", cnt0, 2);
        check("s2_cnt1", cnt1, 2);
        @(posedge clk); #1;

        // Stream 0 empty, stream 1 two words, only FU0 ready.
        clear_mem();
        mem1['h60] = 8'h33; mem1['h61] = 8'h44;
        r1 = 1'b0;
        do_start(8'h50, 8'h60);
        run_wait(30, 6, -1, n);
        check("s3_fu0_issues", n_v0, 2);
        check("s3_issue_count", sel_hist.size(), 2);
        seq = 4'b0000;
        for (int i = 0; i < 2 && i < sel_hist.size(); i++) seq[i] = sel_hist[i];
        check("s3_selpath_seq", seq, 4'b0011);
        check("s3_cnt0", cnt0, 0);
        check("s3_cnt1", cnt1, 2);
        @(posedge clk); #1;

        // Start re-pulsed during ISSUE must not reload anything.
        clear_mem();
        for (int i = 0; i < 4; i++) begin
            mem0['h70 + i] = 8'h55; mem1['h80 + i] = 8'h66;
        end
        do_start(8'h70, 8'h80);
        run_wait(30, -1, 2, n);
        check("s6_done_latency", n, 6);
        check("s6_dual_issues", n_dual, 4);
        check("s6_cnt0", cnt0, 4);
        check("s6_cnt1", cnt1, 4);
        check("s6_dp0", dp0, 8'h74);
        check("s6_dp1", dp1, 8'h84);
        @(posedge clk); #1;

        // Reset mid-ISSUE once dp0 reaches 0x13, with a coincident start.
        clear_mem();
        for (int i = 0; i < 8; i++) begin
            mem0['h10 + i] = 8'h77; mem1['h20 + i] = 8'h88;
        end
        do_start(8'h10, 8'h20);
        k = 0;
        while (dp0 != 8'h13 && k < 10) begin
            @(posedge clk); #1;
            k++;
        end
        check("s5_reach_0x13", dp0, 8'h13);
        preset = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        check("s5_dp0", dp0, 0);
        check("s5_dp1", dp1, 0);
        check("s5_cnt0", cnt0, 0);
        check("s5_busy", busy, 0);
        check("s5_fu0_valid", fu0_valid, 0);
        check("s5_fu1_valid", fu1_valid, 0);
        check("s5_done", done, 0);
        preset = 1'b0; start = 1'b0;
        @(posedge clk); #1;
        check("s5_still_idle", busy, 0);
        check("s5_no_valid", {fu0_valid, fu1_valid}, 2'b00);

        // 4-bit pointers, no terminator: both streams wrap after 16 issues.
        start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
        n = 0; k = 0; err_before = 1'b1; got_done = 1'b0;
        while (n < 40) begin
            if (v4_0) begin
                k++;
                if (k == 16) err_before = err4;
            end
            if (done4) begin
                got_done = 1'b1;
                break;
            end
            @(posedge clk); #1;
            n++;
        end
        check("s4_done_seen", got_done, 1);
        check("s4_done_latency", n, 18);
        check("s4_fu0_issues", k, 16);
        check("s4_err_before_wrap", err_before, 0);
        check("s4_err", err4, 1);
        check("s4_dp0", dp4_0, 4'h0);
        check("s4_dp1", dp4_1, 4'h5);
        check("s4_cnt0", cnt4_0, 16);
        check("s4_cnt1", cnt4_1, 16);
        @(posedge clk); #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dispatch_ctrl.md
DISPATCH_CTRL -- requirements
Module: dispatch_ctrl

Interface
REQ-001 Parameters SHALL be: AW, 8, data-pointer width; CW, 16, issue-counter width.
REQ-002 The ports SHALL be:
- clk  in  1  clock; all state on rising edge
- preset  in  1  reset; synchronous, active-high
- start  in  1  begin a dispatch run
- base0  in  AW  start address, stream 0
- base1  in  AW  start address, stream 1
- zer0  in  1  word at dp0 is zero (stream 0 terminator)
- zer1  in  1  word at dp1 is zero (stream 1 terminator)
- fu0_ready  in  1  FU0 idle
- fu1_ready  in  1  FU1 idle
- dp0  out  AW  stream 0 pointer
- dp1  out  AW  stream 1 pointer
- selpath  out  1  operand routing: 0 straight, 1 swapped
- fu0_valid  out  1  issue pulse to FU0
- fu1_valid  out  1  issue pulse to FU1
- busy  out  1  run in progress
- done  out  1  one-cycle end-of-run pulse
- err  out  1  a pointer wrapped to its base
- cnt0  out  CW  words issued from stream 0
- cnt1  out  CW  words issued from stream 1

Function
REQ-003 The FSM SHALL have the states IDLE, ISSUE, DRAIN and DONE.
REQ-004 In IDLE with start=1, the block SHALL load dp0<=base0 and dp1<=base1, clear cnt0, cnt1 and err, and go to ISSUE; start SHALL be ignored in every other state.
REQ-005 In ISSUE, live0=~zer0 and live1=~zer1; when live0=live1=0 the FSM SHALL go to DRAIN with no issue that cycle.
REQ-006 With both FUs ready, both streams live: selpath=0, fu0_valid=fu1_valid=1, both pointers advance.
REQ-007 With both FUs ready, one stream live: selpath=0; only the straight-path FU is issued (stream0->FU0, stream1->FU1).
REQ-008 With only FU0 ready: only live0 -> selpath=0; only live1 -> selpath=1; both live -> serve stream rr (selpath=rr), then toggle rr.
REQ-009 With only FU1 ready: only live0 -> selpath=1; only live1 -> selpath=0; both live -> serve stream rr (selpath=~rr), then toggle rr.
REQ-010 With no FU ready, there SHALL be no issue, and selpath SHALL hold its previous value.
REQ-011 fuN_valid SHALL be combinational, asserted only while fuN_ready=1 in ISSUE; the FU drops ready from the next cycle if it is busy.
REQ-012 Each served stream SHALL have its dpN incremented and cntN incremented on the issue edge; zerN for the new address is evaluated the following cycle (1 issue/cycle/stream).
REQ-013 Pointers SHALL wrap modulo 2^AW; if an increment makes dpN equal baseN, stream N SHALL be forced dead for the rest of the run and err SHALL be set (sticky until next start).
REQ-014 cntN SHALL saturate at all ones.
REQ-015 In DRAIN, when fu0_ready=fu1_ready=1 the FSM SHALL go to DONE; in DONE, done=1 for one cycle, then IDLE.
REQ-016 busy SHALL be 1 in ISSUE and DRAIN, and 0 otherwise.

Reset
REQ-017 preset=1 SHALL force, at the next edge from any state, including mid-run: IDLE, dp0=dp1=0, cnt0=cnt1=0, rr=0, selpath=0, err=0; fu0_valid, fu1_valid, busy and done SHALL be 0.
REQ-018 A start coincident with preset SHALL be ignored.

Structure
REQ-019 The state encoding and the AW/CW defaults SHALL live in the shared package dispatch_pkg.
REQ-020 One sub-module, stream_ptr (pointer, saturating counter, wrap detection), SHALL be instantiated twice.
REQ-021 selpath SHALL drive the existing operand router directly.

Verification
REQ-022 Bench scenarios SHALL be:
- base0=0x10 with 3 nonzero words then 0, base1=0x20 with 3 nonzero words then 0, FUs always ready -> 3 dual issues with selpath=0, then DRAIN, done 5 cycles after start, cnt0=cnt1=3.
- Both streams live, fu1_ready=0, fu0_ready=1 -> selpath sequence 0,1,0,1; dp0 and dp1 advance alternately.
- Stream0 empty at base, fu1_ready=0, stream1 holding 2 words -> selpath=1 twice, fu0_valid twice, cnt1=2, cnt0=0.
- AW=4, base0=0, no zero word in memory -> after 16 issues dp0=0, err=1, run terminates with done.
- preset asserted mid-ISSUE with dp0=0x13 -> next cycle IDLE, dp0=0, busy=0, no valid pulses.
- start pulsed during ISSUE -> pointers and counters unaffected.
